// File: rtl/serial_operand_serializer_pkg.sv
// rtl/serial_operand_serializer_pkg.sv - shared state type for the serializer and a future deserializer
package serial_operand_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/serial_operand_serializer_if.sv
// rtl/serial_operand_serializer_if.sv - parallel operand upstream port and serial adder downstream port
interface serial_operand_serializer_if #(
    parameter int W = 8
);
    localparam int LW = $clog2(W + 1);

    logic          in_vld;
    logic          in_rdy;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [LW-1:0] in_len;
    logic          hold;
    logic          vld;
    logic          a;
    logic          b;
    logic          last;

    modport master (
        output in_vld, in_a, in_b, in_len, hold,
        input  in_rdy, vld, a, b, last
    );

    modport slave (
        input  in_vld, in_a, in_b, in_len, hold,
        output in_rdy, vld, a, b, last
    );
endinterface

// File: rtl/serial_operand_serializer.sv
// rtl/serial_operand_serializer.sv - LSB-first serializer of operand pairs for the serial adder
module serial_operand_serializer
    import serial_operand_serializer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    serial_operand_serializer_if.slave    bus
);
    localparam int LW = $clog2(W + 1);
    localparam logic [LW-1:0] W_L   = LW'(W);
    localparam logic [LW-1:0] ONE_L = LW'(1);

    ser_state_t    state_q, state_d;
    logic [W-1:0]  sh_a_q, sh_a_d;
    logic [W-1:0]  sh_b_q, sh_b_d;
    logic [LW-1:0] cnt_q, cnt_d;

    logic emit, rdy, accept;
    logic vld_o, a_o, b_o, last_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        cnt_d   = cnt_q;
        vld_o   = 1'b0;
        a_o     = 1'b0;
        b_o     = 1'b0;
        last_o  = 1'b0;

        emit = (state_q == SHIFT) && !bus.hold;
        // rst gates in_rdy because the async clear already puts state_q in IDLE
        rdy  = !rst && ((state_q == IDLE) || (emit && cnt_q == ONE_L));
        accept = bus.in_vld && rdy;

        if (emit) begin
            vld_o  = 1'b1;
            a_o    = sh_a_q[0];
            b_o    = sh_b_q[0];
            last_o = (cnt_q == ONE_L);
            sh_a_d = sh_a_q >> 1;
            sh_b_d = sh_b_q >> 1;
            cnt_d  = cnt_q - ONE_L;
            if (cnt_q == ONE_L) begin
                state_d = IDLE;
            end
        end

        if (accept) begin
            sh_a_d  = bus.in_a;
            sh_b_d  = bus.in_b;
            cnt_d   = (bus.in_len == '0 || bus.in_len > W_L) ? W_L : bus.in_len;
            state_d = SHIFT;
        end
    end

    assign bus.in_rdy = rdy;
    assign bus.vld    = vld_o;
    assign bus.a      = a_o;
    assign bus.b      = b_o;
    assign bus.last   = last_o;

endmodule
